// File: rtl/attn_pkg.sv
// Shared types and constants for the attention operand transmitter.
// The default sizes here set the host address map (q first, then key rows).
package attn_pkg;

  localparam int ATTN_N_FEAT = 4;
  localparam int ATTN_N_ROWS = 4;
  localparam int K_BASE      = ATTN_N_FEAT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_t;

  // Flat buffer index for a stream position: q[feat] or k[row][feat].
  function automatic int operand_index(input logic phase, input int feat,
                                       input int row, input int n_feat);
    return phase ? (n_feat + row * n_feat + feat) : feat;
  endfunction

endpackage

// File: rtl/attn_operand_mem.sv
// Operand buffer: one query vector plus N_ROWS key rows, host-writable,
// synchronously cleared, read combinationally by stream position.
module attn_operand_mem
  import attn_pkg::*;
#(
  parameter int N_FEAT = ATTN_N_FEAT,
  parameter int N_ROWS = ATTN_N_ROWS,
  parameter int AW     = $clog2(N_FEAT * (N_ROWS + 1))
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [7:0]                wr_data,
  input  logic                      rd_phase,
  input  logic [$clog2(N_FEAT)-1:0] rd_feat,
  input  logic [$clog2(N_ROWS)-1:0] rd_row,
  output logic [7:0]                rd_data
);

  localparam int DEPTH = N_FEAT * (N_ROWS + 1);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic          wr_hit;
  logic [AW-1:0] rd_idx;

  // Addresses past the last key entry are legal encodings but map to nothing.
  always_comb begin
    wr_hit = wr_en && (int'(wr_addr) < DEPTH);
    mem_d  = mem_q;
    if (wr_hit) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_idx = AW'(operand_index(rd_phase, int'(rd_feat), int'(rd_row), N_FEAT));
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/attn_operand_tx.sv
// Streams q/k interleaved operand beats to the attention engine over a
// valid/ready link; the host loads the buffer only while idle.
module attn_operand_tx
  import attn_pkg::*;
#(
  parameter int N_FEAT = ATTN_N_FEAT,
  parameter int N_ROWS = ATTN_N_ROWS,
  parameter int AW     = $clog2(N_FEAT * (N_ROWS + 1))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [7:0]    tx_data,
  output logic          tx_vld,
  input  logic          tx_rdy
);

  localparam int FW = $clog2(N_FEAT);
  localparam int RW = $clog2(N_ROWS);
  localparam logic [FW-1:0] FEAT_LAST = FW'(N_FEAT - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(N_ROWS - 1);

  tx_state_t     state_q, state_d;
  logic          phase_q, phase_d;
  logic [FW-1:0] feat_q, feat_d;
  logic [RW-1:0] row_q, row_d;
  logic          fire;
  logic          last_beat;
  logic          buf_wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      feat_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      feat_q  <= feat_d;
      row_q   <= row_d;
    end
  end

  // Counters form one odometer: phase is the fastest digit, then feat, then row.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    feat_d    = feat_q;
    row_d     = row_q;
    fire      = (state_q == SEND) && tx_rdy;
    last_beat = fire && phase_q && (feat_q == FEAT_LAST) && (row_q == ROW_LAST);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          phase_d = 1'b0;
          feat_d  = '0;
          row_d   = '0;
        end
      end
      SEND: begin
        if (fire) begin
          phase_d = ~phase_q;
          if (phase_q) begin
            feat_d = feat_q + 1'b1;
            if (feat_q == FEAT_LAST) begin
              row_d = row_q + 1'b1;
            end
          end
        end
        if (last_beat) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Valid is purely a state decode so it never depends on tx_rdy.
  assign busy      = (state_q == SEND);
  assign tx_vld    = (state_q == SEND);
  assign done      = (state_q == DONE);
  assign buf_wr_en = wr_en && (state_q == IDLE);

  attn_operand_mem #(
    .N_FEAT (N_FEAT),
    .N_ROWS (N_ROWS),
    .AW     (AW)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (buf_wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_phase (phase_q),
    .rd_feat  (feat_q),
    .rd_row   (row_q),
    .rd_data  (tx_data)
  );

endmodule

// File: tb/tb_attn_operand_tx.sv
// Scoreboard bench for attn_operand_tx: runs push expected beats into a queue
// and an independent negedge monitor pops and compares on every handshake.
module tb_attn_operand_tx;
  import attn_pkg::*;

  localparam int NF    = ATTN_N_FEAT;
  localparam int NR    = ATTN_N_ROWS;
  localparam int DEPTH = NF * (NR + 1);
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [7:0]    tx_data;
  logic          tx_vld;
  logic          tx_rdy = 1'b0;

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] model [DEPTH];
  logic [7:0] exp_q [$];
  bit         stall_prev = 1'b0;
  logic [7:0] held = '0;

  always #5 clk = ~clk;

  attn_operand_tx dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .tx_data (tx_data),
    .tx_vld  (tx_vld),
    .tx_rdy  (tx_rdy)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: compares each transferred beat and checks held beats during stalls.
  always @(negedge clk) begin
    if (stall_prev) begin
      check_output("stall_vld", 32'(tx_vld), 32'd1);
      check_output("stall_data", 32'(tx_data), 32'(held));
    end
    if (tx_vld && tx_rdy) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL beat_extra: got 0x%0h expected no beat", tx_data);
      end else begin
        check_output("beat", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
    stall_prev = tx_vld && !tx_rdy;
    held       = tx_data;
  end

  task automatic write_entry(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (a < DEPTH) model[a] = d;
  endtask

  task automatic push_expected();
    for (int r = 0; r < NR; r++) begin
      for (int f = 0; f < NF; f++) begin
        exp_q.push_back(model[f]);
        exp_q.push_back(model[K_BASE + r * NF + f]);
      end
    end
  endtask

  // One streaming run; called and returns #1 after a rising edge in IDLE.
  task automatic apply_stimulus(input bit toggle_rdy, input int poke_at,
                                input int reset_at, input int exp_done,
                                input bit wr_with_start, input int wa,
                                input logic [7:0] wd);
    int done_k;
    bit was_reset;
    if (wr_with_start) begin
      wr_en   = 1'b1;
      wr_addr = AW'(wa);
      wr_data = wd;
      if (wa < DEPTH) model[wa] = wd;
    end
    push_expected();
    start  = 1'b1;
    tx_rdy = 1'b0;
    @(posedge clk);
    #1;
    start     = 1'b0;
    wr_en     = 1'b0;
    done_k    = -1;
    was_reset = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      tx_rdy = toggle_rdy ? (k % 2 == 0) : 1'b1;
      if (k == 1) begin
        check_output("vld_first", 32'(tx_vld), 32'd1);
        check_output("busy_first", 32'(busy), 32'd1);
      end
      if (k == poke_at) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 8'h7F;
      end
      if (k == reset_at) rst = 1'b1;
      @(negedge clk);
      if (done) begin
        done_k = k;
        break;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      wr_en = 1'b0;
      if (rst) begin
        rst       = 1'b0;
        was_reset = 1'b1;
        break;
      end
    end
    tx_rdy = 1'b0;
    if (was_reset) begin
      check_output("rst_vld", 32'(tx_vld), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_done", 32'(done), 32'd0);
      check_output("rst_data", 32'(tx_data), 32'd0);
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
      repeat (3) begin
        @(posedge clk);
        #1;
        check_output("rst_no_done", 32'(done), 32'd0);
      end
    end else begin
      check_output("done_cycle", 32'(done_k), 32'(exp_done));
      check_output("done_vld", 32'(tx_vld), 32'd0);
      check_output("done_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check_output("done_pulse", 32'(done), 32'd0);
      check_output("idle_busy", 32'(busy), 32'd0);
      check_output("beats_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_vld", 32'(tx_vld), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_data", 32'(tx_data), 32'd0);
    rst = 1'b0;

    write_entry(0, 8'h40);
    write_entry(1, 8'h20);
    write_entry(2, 8'hE0);
    write_entry(3, 8'h10);
    for (int r = 0; r < NR; r++)
      for (int f = 0; f < NF; f++)
        write_entry(K_BASE + r * NF + f, 8'(16 * r + f));

    $display("[TB] full-rate stream");
    apply_stimulus(1'b0, -1, -1, 33, 1'b0, 0, 8'h00);
    $display("[TB] alternating ready");
    apply_stimulus(1'b1, -1, -1, 65, 1'b0, 0, 8'h00);
    $display("[TB] start and write during stream");
    apply_stimulus(1'b0, 5, -1, 33, 1'b0, 0, 8'h00);
    apply_stimulus(1'b0, -1, -1, 33, 1'b0, 0, 8'h00);
    $display("[TB] write with start");
    apply_stimulus(1'b0, -1, -1, 33, 1'b1, 0, 8'h55);
    $display("[TB] out-of-range write");
    write_entry(20, 8'h99);
    apply_stimulus(1'b0, -1, -1, 33, 1'b0, 0, 8'h00);
    $display("[TB] reset mid-stream");
    apply_stimulus(1'b0, -1, 10, -1, 1'b0, 0, 8'h00);
    apply_stimulus(1'b0, -1, -1, 33, 1'b0, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
